// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle control unit: control state
// encoding, default datapath width, reset PC and instruction size.
package mc_pkg;

    localparam int unsigned XLEN       = 32;
    localparam logic [31:0] RESET_PC   = 32'h1c00_0000;
    localparam int unsigned INST_BYTES = 4;

    // IF_REQ must stay at encoding 0 so a cleared state register means "fetch"
    typedef enum logic [2:0] {
        IF_REQ   = 3'd0,
        IF_WAIT  = 3'd1,
        ID       = 3'd2,
        EXE      = 3'd3,
        MEM_REQ  = 3'd4,
        MEM_WAIT = 3'd5,
        WB       = 3'd6
    } state_e;

endpackage

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit with req/addr_ok/data_ok handshakes on the
// instruction and data SRAM ports. Owns PC, IR, next-PC, result register
// and the retire counter; decode/regfile/ALU live outside and feed back
// classification bits derived from ir.
module mc_ctrl #(
    parameter int unsigned       XLEN     = mc_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(mc_pkg::RESET_PC),
    parameter int unsigned       CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    // instruction SRAM
    output logic              inst_req,
    output logic [XLEN-1:0]   inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [31:0]       inst_rdata,
    // decoder interface
    output logic [31:0]       ir,
    input  logic              dec_no_exe,
    input  logic              dec_is_load,
    input  logic              dec_is_store,
    input  logic              dec_gr_we,
    input  logic              br_taken,
    input  logic [XLEN-1:0]   br_target,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   store_data,
    // data SRAM
    output logic              data_req,
    output logic              data_wr,
    output logic [XLEN-1:0]   data_addr,
    output logic [XLEN-1:0]   data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [XLEN-1:0]   data_rdata,
    // regfile write port
    output logic              rf_we,
    output logic [XLEN-1:0]   rf_wdata,
    // status
    output logic [XLEN-1:0]   pc,
    output logic              retire,
    output logic [CNT_W-1:0]  retire_cnt
);

    import mc_pkg::*;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [XLEN-1:0]     npc_q, npc_d;
    logic [31:0]         ir_q, ir_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [CNT_W-1:0]    retire_cnt_q, retire_cnt_d;

    logic [XLEN-1:0]     seq_pc;
    logic                store_done;

    // Sequential PC wraps naturally at 2^XLEN
    assign seq_pc     = pc_q + XLEN'(INST_BYTES);
    assign store_done = (state_q == MEM_WAIT) && data_data_ok && dec_is_store;

    // Port outputs decode the registered state; reset forces strobes low
    // because the state already reads IF_REQ while reset is still held.
    assign inst_req   = !reset && (state_q == IF_REQ);
    assign inst_addr  = pc_q;
    assign data_req   = !reset && (state_q == MEM_REQ);
    assign data_wr    = data_req && dec_is_store;
    assign data_addr  = res_q;
    assign data_wdata = wdata_q;
    assign rf_we      = !reset && (state_q == WB) && dec_gr_we;
    assign rf_wdata   = res_q;
    assign retire     = !reset && (((state_q == ID) && dec_no_exe) ||
                                   (state_q == WB) || store_done);
    assign ir         = ir_q;
    assign pc         = pc_q;
    assign retire_cnt = retire_cnt_q;

    // Next-state and datapath register updates; data_ok is only honoured
    // in its own WAIT state so stale responses fall through harmlessly.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        npc_d        = npc_q;
        ir_d         = ir_q;
        res_d        = res_q;
        wdata_d      = wdata_q;
        retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, retire};
        case (state_q)
            IF_REQ: begin
                if (inst_addr_ok) state_d = IF_WAIT;
            end
            IF_WAIT: begin
                if (inst_data_ok) begin
                    ir_d    = inst_rdata;
                    state_d = ID;
                end
            end
            ID: begin
                npc_d = br_taken ? br_target : seq_pc;
                if (dec_no_exe) begin
                    pc_d    = npc_d;
                    state_d = IF_REQ;
                end else begin
                    state_d = EXE;
                end
            end
            EXE: begin
                res_d   = alu_result;
                wdata_d = store_data;
                state_d = (dec_is_load || dec_is_store) ? MEM_REQ : WB;
            end
            MEM_REQ: begin
                if (data_addr_ok) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (data_data_ok) begin
                    if (dec_is_store) begin
                        pc_d    = npc_q;
                        state_d = IF_REQ;
                    end else begin
                        res_d   = data_rdata;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                pc_d    = npc_q;
                state_d = IF_REQ;
            end
            default: state_d = IF_REQ;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IF_REQ;
            pc_q         <= RESET_PC;
            npc_q        <= '0;
            ir_q         <= '0;
            res_q        <= '0;
            wdata_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            npc_q        <= npc_d;
            ir_q         <= ir_d;
            res_q        <= res_d;
            wdata_q      <= wdata_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

endmodule
